bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Bus arbiter: shares one memory-side bus among CHANNELS masters.
// Two-state FSM (IDLE/GRANT). Arbitration is either fixed priority or
// round-robin. The granted master's signals pass through to the memory
// side combinationally.
module bus_arbiter #(
  parameter int CHANNELS   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic [CHANNELS*ADDR_WIDTH-1:0]      i_m_addr,
  input  logic [CHANNELS-1:0]                 i_m_re,
  input  logic [CHANNELS-1:0]                 i_m_we,
  input  logic [CHANNELS*(DATA_WIDTH/8)-1:0]  i_m_be,
  input  logic [CHANNELS*DATA_WIDTH-1:0]      i_m_wdata,
  output logic [DATA_WIDTH-1:0]               o_m_rdata,
  output logic [CHANNELS-1:0]                 o_m_busy,
  output logic [ADDR_WIDTH-1:0]               o_s_addr,
  output logic                                o_s_re,
  output logic                                o_s_we,
  output logic [DATA_WIDTH/8-1:0]             o_s_be,
  output logic [DATA_WIDTH-1:0]               o_s_wdata,
  input  logic [DATA_WIDTH-1:0]               i_s_rdata,
  input  logic                                i_s_busy,
  output logic [CHANNELS-1:0]                 o_grant
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(CHANNELS);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [CHANNELS-1:0] req_s;
  logic [CHANNELS-1:0] win_s;
  logic [PTR_W-1:0]    gidx_s;
  logic                g_req_s;

  assign req_s     = i_m_re | i_m_we;
  assign o_grant   = grant_q;
  assign o_m_rdata = i_s_rdata;

  // Winner selection: scan channels starting at rr_ptr (round-robin) or 0 (fixed).
  always_comb begin : p_select
    int               tmp;
    logic [PTR_W-1:0] idx;
    logic             found;
    win_s = '0;
    found = 1'b0;
    tmp   = 0;
    idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ARB_MODE == 1) begin
        tmp = int'(rr_ptr_q) + k;
      end else begin
        tmp = k;
      end
      if (tmp >= CHANNELS) begin
        tmp = tmp - CHANNELS;
      end else begin
        tmp = tmp;
      end
      idx = PTR_W'(tmp);
      if (!found && req_s[idx]) begin
        win_s[idx] = 1'b1;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Memory-side mux and per-channel stall; grant_q is one-hot or zero, so an OR-mux suffices.
  always_comb begin : p_mux
    gidx_s    = '0;
    g_req_s   = 1'b0;
    o_s_addr  = '0;
    o_s_re    = 1'b0;
    o_s_we    = 1'b0;
    o_s_be    = '0;
    o_s_wdata = '0;
    o_m_busy  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_q[i]) begin
        gidx_s      = PTR_W'(i);
        g_req_s     = req_s[i];
        o_s_addr    = o_s_addr  | i_m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        o_s_re      = o_s_re    | i_m_re[i];
        o_s_we      = o_s_we    | i_m_we[i];
        o_s_be      = o_s_be    | i_m_be[i*BE_W +: BE_W];
        o_s_wdata   = o_s_wdata | i_m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        o_m_busy[i] = i_s_busy;
      end else begin
        o_m_busy[i] = req_s[i];
      end
    end
  end

  // Next-state logic: grant on request, release on completion or abort.
  always_comb begin : p_next
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|req_s) begin
          state_d = S_GRANT;
          grant_d = win_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (!g_req_s) begin
          // Master withdrew its request: release without moving the pointer.
          state_d = S_IDLE;
          grant_d = '0;
        end else if (!i_s_busy) begin
          state_d = S_IDLE;
          grant_d = '0;
          if (gidx_s == PTR_W'(CHANNELS - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = gidx_s + PTR_W'(1);
          end
        end else begin
          state_d = S_GRANT;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
